// File: rtl/scurve_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// scurve_sweep_ctrl
// Runs a full S-curve threshold scan around the pulse/trigger counter. For each
// DAC point it loads the code, waits for the threshold to settle, clears and
// arms the counter, waits for the counter's done flag and streams three words
// (DAC code, pulse count, trigger count) over a valid/ready handshake.
//
// Ports:
//   Clk, reset_n              system clock, asynchronous active-low reset
//   Sweep_Start / Sweep_Abort start pulse (IDLE only) / synchronous abort
//   DAC_Start/End/Step        scan settings, latched when a start is accepted
//   DAC_Code, DAC_Load        threshold code and its one-cycle load strobe
//   Cnt_Reset_n, Test_Start   counter clear (active low) and arm level
//   CPT_DONE/PULSE/TRIGGER    counter results (CPT_DONE is asynchronous to Clk)
//   Data_Out/Valid/Ready      readout word stream
//   Sweep_Busy, Sweep_Done    status: busy outside IDLE, done pulse at the end
// -----------------------------------------------------------------------------
module scurve_sweep_ctrl #(
   parameter int DAC_WIDTH     = 10,
   parameter int SETTLE_CYCLES = 1000,
   parameter int CLEAR_CYCLES  = 4
) (
   input  logic                 Clk,
   input  logic                 reset_n,
   input  logic                 Sweep_Start,
   input  logic                 Sweep_Abort,
   input  logic [DAC_WIDTH-1:0] DAC_Start,
   input  logic [DAC_WIDTH-1:0] DAC_End,
   input  logic [DAC_WIDTH-1:0] DAC_Step,
   output logic [DAC_WIDTH-1:0] DAC_Code,
   output logic                 DAC_Load,
   output logic                 Cnt_Reset_n,
   output logic                 Test_Start,
   input  logic                 CPT_DONE,
   input  logic [15:0]          CPT_PULSE,
   input  logic [15:0]          CPT_TRIGGER,
   output logic [15:0]          Data_Out,
   output logic                 Data_Valid,
   input  logic                 Data_Ready,
   output logic                 Sweep_Busy,
   output logic                 Sweep_Done
);

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_LOAD    = 4'd1,
      ST_SETTLE  = 4'd2,
      ST_CLEAR   = 4'd3,
      ST_ARM     = 4'd4,
      ST_CAPTURE = 4'd5,
      ST_SEND    = 4'd6,
      ST_NEXT    = 4'd7,
      ST_FINISH  = 4'd8
   } state_t;

   localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0] CLEAR_LAST  = 32'(CLEAR_CYCLES - 1);

   state_t               state_r, state_s;
   logic [31:0]          cnt_r, cnt_s;
   logic [1:0]           word_idx_r, word_idx_s;
   logic [DAC_WIDTH-1:0] dac_end_r, dac_step_r;
   logic [DAC_WIDTH-1:0] dac_code_r, dac_code_s;
   logic [15:0]          pulse_r, trigger_r;
   logic [15:0]          data_out_r, data_out_s;
   logic [1:0]           sync_r;
   logic                 done_prev_r;
   logic                 dac_load_r, cnt_reset_n_r, test_start_r;
   logic                 data_valid_r, sweep_busy_r, sweep_done_r;
   logic                 latch_cfg_s, capture_s, done_rise_s;
   logic [DAC_WIDTH-1:0] step_eff_s;
   logic [DAC_WIDTH:0]   next_code_s;

   assign done_rise_s = sync_r[1] & ~done_prev_r;
   // A zero step would never advance the scan, so it behaves as a step of one.
   assign step_eff_s  = (dac_step_r == {DAC_WIDTH{1'b0}}) ?
                        {{(DAC_WIDTH-1){1'b0}}, 1'b1} : dac_step_r;
   // One bit wider so a carry out of the code range also ends the scan.
   assign next_code_s = {1'b0, dac_code_r} + {1'b0, step_eff_s};

   // Next-state and next-value logic for the scan sequencer.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      word_idx_s  = word_idx_r;
      dac_code_s  = dac_code_r;
      data_out_s  = data_out_r;
      latch_cfg_s = 1'b0;
      capture_s   = 1'b0;
      if (Sweep_Abort) begin
         state_s    = ST_IDLE;
         cnt_s      = 32'd0;
         word_idx_s = 2'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (Sweep_Start) begin
                  latch_cfg_s = 1'b1;
                  cnt_s       = 32'd0;
                  if (DAC_Start > DAC_End) begin
                     state_s = ST_FINISH;
                  end else begin
                     dac_code_s = DAC_Start;
                     state_s    = ST_LOAD;
                  end
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_LOAD: begin
               cnt_s   = 32'd0;
               state_s = ST_SETTLE;
            end
            ST_SETTLE: begin
               if (cnt_r == SETTLE_LAST) begin
                  cnt_s   = 32'd0;
                  state_s = ST_CLEAR;
               end else begin
                  cnt_s = cnt_r + 32'd1;
               end
            end
            ST_CLEAR: begin
               if (cnt_r == CLEAR_LAST) begin
                  cnt_s   = 32'd0;
                  state_s = ST_ARM;
               end else begin
                  cnt_s = cnt_r + 32'd1;
               end
            end
            ST_ARM: begin
               // A rise within the first two ARM cycles is a stale flag still
               // working its way through the synchroniser.
               if (done_rise_s && (cnt_r >= 32'd2)) begin
                  state_s = ST_CAPTURE;
               end else if (cnt_r < 32'd2) begin
                  cnt_s = cnt_r + 32'd1;
               end else begin
                  cnt_s = cnt_r;
               end
            end
            ST_CAPTURE: begin
               capture_s  = 1'b1;
               word_idx_s = 2'd0;
               data_out_s = 16'(dac_code_r);
               state_s    = ST_SEND;
            end
            ST_SEND: begin
               if (Data_Ready) begin
                  if (word_idx_r == 2'd2) begin
                     state_s = ST_NEXT;
                  end else begin
                     word_idx_s = word_idx_r + 2'd1;
                     data_out_s = (word_idx_r == 2'd0) ? pulse_r : trigger_r;
                  end
               end else begin
                  state_s = ST_SEND;
               end
            end
            ST_NEXT: begin
               if (next_code_s > {1'b0, dac_end_r}) begin
                  state_s = ST_FINISH;
               end else begin
                  dac_code_s = next_code_s[DAC_WIDTH-1:0];
                  state_s    = ST_LOAD;
               end
            end
            ST_FINISH: begin
               state_s = ST_IDLE;
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // State, datapath and registered outputs; outputs follow the next state so
   // each one is aligned with the state it belongs to.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_IDLE;
         cnt_r         <= 32'd0;
         word_idx_r    <= 2'd0;
         dac_end_r     <= {DAC_WIDTH{1'b0}};
         dac_step_r    <= {DAC_WIDTH{1'b0}};
         dac_code_r    <= {DAC_WIDTH{1'b0}};
         pulse_r       <= 16'd0;
         trigger_r     <= 16'd0;
         data_out_r    <= 16'd0;
         dac_load_r    <= 1'b0;
         cnt_reset_n_r <= 1'b1;
         test_start_r  <= 1'b0;
         data_valid_r  <= 1'b0;
         sweep_busy_r  <= 1'b0;
         sweep_done_r  <= 1'b0;
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         word_idx_r    <= word_idx_s;
         dac_code_r    <= dac_code_s;
         data_out_r    <= data_out_s;
         if (latch_cfg_s) begin
            dac_end_r  <= DAC_End;
            dac_step_r <= DAC_Step;
         end
         if (capture_s) begin
            pulse_r   <= CPT_PULSE;
            trigger_r <= CPT_TRIGGER;
         end
         dac_load_r    <= (state_s == ST_LOAD);
         cnt_reset_n_r <= (state_s != ST_CLEAR);
         test_start_r  <= (state_s == ST_ARM);
         data_valid_r  <= (state_s == ST_SEND);
         sweep_busy_r  <= (state_s != ST_IDLE);
         sweep_done_r  <= (state_s == ST_FINISH);
      end
   end

   // Two-flop synchroniser for the counter done flag plus its edge history.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r      <= 2'b00;
         done_prev_r <= 1'b0;
      end else begin
         sync_r      <= {sync_r[0], CPT_DONE};
         done_prev_r <= sync_r[1];
      end
   end

   assign DAC_Code    = dac_code_r;
   assign DAC_Load    = dac_load_r;
   assign Cnt_Reset_n = cnt_reset_n_r;
   assign Test_Start  = test_start_r;
   assign Data_Out    = data_out_r;
   assign Data_Valid  = data_valid_r;
   assign Sweep_Busy  = sweep_busy_r;
   assign Sweep_Done  = sweep_done_r;

endmodule

// File: doc/scurve_sweep_ctrl.md
Name: scurve_sweep_ctrl

Overview:
Sequences a full S-curve threshold scan around the single-input pulse/trigger counter. For each point it steps the discriminator DAC code and waits for the threshold to settle. It then clears and arms the counter, waits for count completion and streams the DAC code plus both counts to the readout path over a valid/ready handshake. It sits between the slow-control register bank (scan settings) and the readout FIFO.

Parameters:
DAC_WIDTH, 10, width of threshold DAC code
SETTLE_CYCLES, 1000, Clk cycles waited after DAC load before arming the counter (min 1)
CLEAR_CYCLES, 4, Clk cycles the counter reset is held low (min 1)

Ports:
Clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
Sweep_Start  in  1  single-cycle start pulse, honoured only in IDLE
Sweep_Abort  in  1  synchronous abort, any state
DAC_Start  in  DAC_WIDTH  first threshold code
DAC_End  in  DAC_WIDTH  last allowed threshold code (inclusive)
DAC_Step  in  DAC_WIDTH  code increment; 0 treated as 1
DAC_Code  out  DAC_WIDTH  threshold code to DAC driver
DAC_Load  out  1  one-cycle pulse when DAC_Code changes
Cnt_Reset_n  out  1  active-low clear to counter block
Test_Start  out  1  counter arm level
CPT_DONE  in  1  counter done flag (CLK_EXT domain, asynchronous to Clk)
CPT_PULSE  in  16  injected-pulse count
CPT_TRIGGER  in  16  trigger count
Data_Out  out  16  result word
Data_Valid  out  1  Data_Out valid
Data_Ready  in  1  downstream accepts word
Sweep_Busy  out  1  high in every state except IDLE
Sweep_Done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset values: DAC_Code=0, DAC_Load=0, Cnt_Reset_n=1, Test_Start=0, Data_Out=0, Data_Valid=0, Sweep_Busy=0, Sweep_Done=0; state IDLE.
- Scan settings latched on accepted Sweep_Start; later input changes are ignored until the next start.
- CPT_DONE passes through a 2-flop synchroniser (reset 0). "done_rise" = the synchronised value is 1 and the previous value was 0.
- States and transitions:
  - IDLE: on Sweep_Start, if DAC_Start>DAC_End go to FINISH (zero points); otherwise DAC_Code<=DAC_Start and go to LOAD.
  - LOAD: DAC_Load=1 for exactly one cycle, then SETTLE.
  - SETTLE: hold for SETTLE_CYCLES cycles, then CLEAR.
  - CLEAR: Cnt_Reset_n=0 for CLEAR_CYCLES cycles, then ARM.
  - ARM: Test_Start=1. Wait for done_rise; done_rise seen in the first 2 cycles of ARM is ignored (stale flag). On done_rise go to CAPTURE.
  - CAPTURE: latch CPT_PULSE and CPT_TRIGGER, drop Test_Start, go to SEND.
  - SEND: emit 3 words in order: {zero-pad, DAC_Code}, pulse, trigger. Each word: Data_Valid high with Data_Out stable until a cycle with Data_Ready=1. The word transfers on that edge and the next word, if any, is presented the following cycle. Data_Ready already high when valid rises means a 1-cycle transfer; there is no combinational path from Ready to Valid. After the 3rd transfer go to NEXT.
  - NEXT: next = DAC_Code + max(DAC_Step,1), computed DAC_WIDTH+1 bits wide. If next > DAC_End (including carry-out) go to FINISH; otherwise DAC_Code<=next[DAC_WIDTH-1:0] and go to LOAD.
  - FINISH: Sweep_Done=1 for one cycle, then IDLE. DAC_Code keeps its last value.
- Sweep_Abort: on the next edge, go to IDLE from any state. Test_Start=0, Cnt_Reset_n=1, Data_Valid=0, and the partial point is dropped. No Sweep_Done is produced.
- Sweep_Abort has priority over every other transition. Sweep_Start in the same cycle as Sweep_Abort is ignored.
- Sweep_Start outside IDLE is ignored.
- Async reset mid-scan returns every output to its reset value immediately.
- Each point emits exactly 3 words. Total words = 3 × number of points.

Test Plan:
- Start=100, End=104, Step=2, Ready tied 1, counter model done after 50 pulses with 20 triggers -> 3 points (100,102,104), 9 words: 100,50,20,102,50,20,104,50,20; one Sweep_Done pulse.
- Start=1020, End=1023, Step=5 -> single point at 1020, NEXT carry/limit ends the scan, 3 words, Sweep_Done.
- Start=10, End=5 -> no DAC_Load, no words, Sweep_Done 1 cycle after start pulse.
- Step=0, Start=7, End=9 -> points 7,8,9.
- Data_Ready held low 30 cycles during the 2nd word -> Data_Out/Data_Valid stable for all 30 cycles, no word lost or duplicated.
- Sweep_Abort asserted in ARM -> Test_Start low and Sweep_Busy low the next cycle, no words or Sweep_Done. A following Sweep_Start runs a clean scan.
